// File: rtl/elevator_ctrl_if.sv
// Elevator controller bus: call buttons and door hold in, indicators out.
//   button_n  floor call buttons, active low, idle 1      (master -> slave)
//   door_hold hold the door open while high               (master -> slave)
//   led       pending call per floor                      (slave -> master)
//   floor     one-hot current floor                       (slave -> master)
//   door      door open                                   (slave -> master)
//   moving    car travelling                              (slave -> master)
//   dir_up    current/last direction, 1 = up              (slave -> master)
interface elevator_ctrl_if #(
  parameter int unsigned FLOORS = 3
);
  logic [FLOORS-1:0] button_n;
  logic              door_hold;
  logic [FLOORS-1:0] led;
  logic [FLOORS-1:0] floor;
  logic              door;
  logic              moving;
  logic              dir_up;

  modport master (
    output button_n, door_hold,
    input  led, floor, door, moving, dir_up
  );

  modport slave (
    input  button_n, door_hold,
    output led, floor, door, moving, dir_up
  );
endinterface

// File: rtl/elevator_ctrl.sv
// SCAN-policy elevator controller for FLOORS floors.
// Latches falling-edge button presses as calls, keeps travelling in the
// current direction while calls lie ahead, times travel per floor and the
// door dwell, and honours a door-hold input.
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active low
//   bus    elevator_ctrl_if.slave (button_n, door_hold in; led, floor,
//          door, moving, dir_up out)
module elevator_ctrl #(
  parameter int unsigned FLOORS        = 3,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  elevator_ctrl_if.slave  bus
);

  localparam int unsigned FW = (FLOORS        > 2) ? $clog2(FLOORS)        : 1;
  localparam int unsigned TW = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES   > 2) ? $clog2(DOOR_CYCLES)   : 1;

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_e;

  state_e            state_q;
  logic [FLOORS-1:0] btn_q;
  logic [FLOORS-1:0] led_q;
  logic [FLOORS-1:0] floor_q;
  logic [FW-1:0]     cur_q;
  logic [TW-1:0]     travel_q;
  logic [DW-1:0]     dwell_q;
  logic              door_q;
  logic              moving_q;
  logic              dir_up_q;

  logic [FLOORS-1:0] press;
  logic [FLOORS-1:0] new_calls;
  logic [FLOORS-1:0] arr_calls;
  logic [FW-1:0]     nxt_cur;
  logic              press_at_cur;
  logic              above, below, ahead, behind;
  logic              at_end, hit;

  always_comb begin
    press        = btn_q & ~bus.button_n;
    press_at_cur = press[cur_q];
    // A press at the current floor only becomes a call while travelling;
    // otherwise it (re)opens the door instead.
    new_calls    = press;
    if (state_q != MOVING) new_calls[cur_q] = 1'b0;

    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (i > 32'(cur_q)) above = above | led_q[i];
      if (i < 32'(cur_q)) below = below | led_q[i];
    end
    ahead  = dir_up_q ? above : below;
    behind = dir_up_q ? below : above;

    at_end  = dir_up_q ? (cur_q == FW'(FLOORS - 1)) : (cur_q == '0);
    nxt_cur = dir_up_q ? cur_q + 1'b1 : cur_q - 1'b1;
    // Presses on the arrival edge are served by this stop.
    arr_calls = led_q | press;
    hit       = at_end ? 1'b0 : arr_calls[nxt_cur];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      btn_q    <= '1;
      led_q    <= '0;
      floor_q  <= FLOORS'(1);
      cur_q    <= '0;
      travel_q <= '0;
      dwell_q  <= '0;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      dir_up_q <= 1'b1;
    end else begin
      btn_q <= bus.button_n;
      led_q <= led_q | new_calls;

      case (state_q)
        IDLE: begin
          if (press_at_cur) begin
            door_q  <= 1'b1;
            dwell_q <= '0;
            state_q <= DOOR_OPEN;
          end else if (|led_q) begin
            moving_q <= 1'b1;
            travel_q <= '0;
            dir_up_q <= above & (dir_up_q | ~below);
            state_q  <= MOVING;
          end
        end

        MOVING: begin
          if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
            travel_q <= '0;
            if (at_end) begin
              // Cannot go further this way; turn toward the remaining calls.
              dir_up_q <= ~dir_up_q;
            end else begin
              cur_q   <= nxt_cur;
              floor_q <= dir_up_q ? (floor_q << 1) : (floor_q >> 1);
              if (hit) begin
                led_q[nxt_cur] <= 1'b0;
                moving_q       <= 1'b0;
                door_q         <= 1'b1;
                dwell_q        <= '0;
                state_q        <= DOOR_OPEN;
              end
            end
          end else begin
            travel_q <= travel_q + 1'b1;
          end
        end

        DOOR_OPEN: begin
          if (bus.door_hold || press_at_cur) begin
            dwell_q <= '0;
          end else if (dwell_q == DW'(DOOR_CYCLES - 1)) begin
            dwell_q <= '0;
            door_q  <= 1'b0;
            if (ahead || behind) begin
              if (!ahead) dir_up_q <= ~dir_up_q;
              moving_q <= 1'b1;
              travel_q <= '0;
              state_q  <= MOVING;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.led    = led_q;
  assign bus.floor  = floor_q;
  assign bus.door   = door_q;
  assign bus.moving = moving_q;
  assign bus.dir_up = dir_up_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl (FLOORS=3, TRAVEL_CYCLES=4, DOOR_CYCLES=3).
// Stimulus pushes cycle-tagged expected indicator snapshots; a negedge
// monitor pops and compares them when their cycle arrives.
module tb_elevator_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  elevator_ctrl_if #(.FLOORS(3)) bus ();

  elevator_ctrl #(
    .FLOORS        (3),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] led;
    logic [2:0] flr;
    logic       door;
    logic       mov;
    logic       dir;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    checks++;
    if (bus.door === 1'b1 && bus.moving === 1'b1) begin
      errors++;
      $display("FAIL door_moving_exclusive cyc=%0d: door=%b moving=%b, required not both 1",
               cyc, bus.door, bus.moving);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_mon = q.pop_front();
      checks++;
      if (e_mon.cyc != cyc ||
          {bus.led, bus.floor, bus.door, bus.moving, bus.dir_up} !==
          {e_mon.led, e_mon.flr, e_mon.door, e_mon.mov, e_mon.dir}) begin
        errors++;
        $display("FAIL %s cyc=%0d (due %0d): got led=%b floor=%b door=%b moving=%b dir_up=%b, expected led=%b floor=%b door=%b moving=%b dir_up=%b",
                 e_mon.nm, cyc, e_mon.cyc, bus.led, bus.floor, bus.door, bus.moving, bus.dir_up,
                 e_mon.led, e_mon.flr, e_mon.door, e_mon.mov, e_mon.dir);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int d, input logic [2:0] led, input logic [2:0] flr,
                           input logic door, input logic mov, input logic dir,
                           input string nm);
    exp_t e;
    e.cyc = cyc + d; e.led = led; e.flr = flr;
    e.door = door; e.mov = mov; e.dir = dir; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    bus.button_n = 3'b111;
    expect_at(1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, nm);
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.button_n  = 3'b111;
    bus.door_hold = 1'b0;

    // 1: reset held for two edges
    tick(1);
    expect_at(1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, "t1_reset");
    tick(1);
    rst_n = 1'b1;

    // 2: single call to floor 1 from floor 0
    bus.button_n = 3'b101;
    expect_at(1,  3'b010, 3'b001, 1'b0, 1'b0, 1'b1, "t2_led");
    expect_at(2,  3'b010, 3'b001, 1'b0, 1'b1, 1'b1, "t2_move");
    expect_at(5,  3'b010, 3'b001, 1'b0, 1'b1, 1'b1, "t2_pre_arrive");
    expect_at(6,  3'b000, 3'b010, 1'b1, 1'b0, 1'b1, "t2_arrive");
    expect_at(8,  3'b000, 3'b010, 1'b1, 1'b0, 1'b1, "t2_door_last");
    expect_at(9,  3'b000, 3'b010, 1'b0, 1'b0, 1'b1, "t2_close");
    expect_at(10, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, "t2_idle");
    tick(1);
    bus.button_n = 3'b111;
    tick(10);

    // 3: floors 1 and 2 together from floor 0
    do_reset("t3_reset");
    bus.button_n = 3'b001;
    expect_at(1,  3'b110, 3'b001, 1'b0, 1'b0, 1'b1, "t3_led");
    expect_at(2,  3'b110, 3'b001, 1'b0, 1'b1, 1'b1, "t3_move");
    expect_at(6,  3'b100, 3'b010, 1'b1, 1'b0, 1'b1, "t3_stop1");
    expect_at(9,  3'b100, 3'b010, 1'b0, 1'b1, 1'b1, "t3_leave1");
    expect_at(13, 3'b000, 3'b100, 1'b1, 1'b0, 1'b1, "t3_stop2");
    expect_at(16, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, "t3_idle");
    tick(1);
    bus.button_n = 3'b111;
    tick(16);

    // 4: call below raised while travelling 1->2
    do_reset("t4_reset");
    bus.button_n = 3'b011;
    expect_at(1,  3'b100, 3'b001, 1'b0, 1'b0, 1'b1, "t4_led");
    expect_at(6,  3'b100, 3'b010, 1'b0, 1'b1, 1'b1, "t4_pass1");
    expect_at(8,  3'b101, 3'b010, 1'b0, 1'b1, 1'b1, "t4_call0");
    expect_at(10, 3'b001, 3'b100, 1'b1, 1'b0, 1'b1, "t4_stop2");
    expect_at(13, 3'b001, 3'b100, 1'b0, 1'b1, 1'b0, "t4_reverse");
    expect_at(17, 3'b001, 3'b010, 1'b0, 1'b1, 1'b0, "t4_pass1_down");
    expect_at(21, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, "t4_stop0");
    expect_at(24, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, "t4_idle");
    tick(1);
    bus.button_n = 3'b111;
    tick(6);
    bus.button_n = 3'b110;
    tick(1);
    bus.button_n = 3'b111;
    tick(17);

    // 5: door hold then re-press at floor 1
    bus.button_n = 3'b101;
    expect_at(1,  3'b010, 3'b001, 1'b0, 1'b0, 1'b0, "t5_led");
    expect_at(6,  3'b000, 3'b010, 1'b1, 1'b0, 1'b1, "t5_arrive");
    expect_at(11, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, "t5_held");
    expect_at(12, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, "t5_repress");
    expect_at(14, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, "t5_door_last");
    expect_at(15, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, "t5_close");
    expect_at(16, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, "t5_idle");
    tick(1);
    bus.button_n = 3'b111;
    tick(5);
    bus.door_hold = 1'b1;
    tick(5);
    bus.door_hold = 1'b0;
    bus.button_n  = 3'b101;
    tick(1);
    bus.button_n = 3'b111;
    tick(5);

    // 6: reset while leaving floor 1 upward with calls at 0 and 2
    bus.button_n = 3'b010;
    expect_at(1, 3'b101, 3'b010, 1'b0, 1'b0, 1'b1, "t6_led");
    expect_at(2, 3'b101, 3'b010, 1'b0, 1'b1, 1'b1, "t6_move");
    expect_at(4, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, "t6_reset");
    tick(1);
    bus.button_n = 3'b111;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    expect_at(1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, "t6_idle");
    tick(2);

    // 7: press at the current floor while idle opens the door, no call
    bus.button_n = 3'b110;
    expect_at(1, 3'b000, 3'b001, 1'b1, 1'b0, 1'b1, "t7_open");
    expect_at(3, 3'b000, 3'b001, 1'b1, 1'b0, 1'b1, "t7_door_last");
    expect_at(4, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, "t7_close");
    expect_at(5, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, "t7_idle");
    tick(1);
    bus.button_n = 3'b111;
    tick(6);

    while (q.size() > 0) begin
      e_mon = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no comparison by cyc=%0d, required at cyc=%0d", e_mon.nm, cyc, e_mon.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
